// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer.
//   state_e       : FSM state encoding (IDLE=0, SETTLE=1, DONE=2)
//   DEF_N_CH      : default number of mux channels scanned
//   DEF_SEL_W     : default select width, log2(DEF_N_CH)
//   DEF_DWELL     : default clock cycles sel is held per channel
//   cnt_width()   : dwell counter width for a given dwell, never below 1
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_SEL_W = 2;
  localparam int DEF_DWELL = 20;

  // A dwell of 1 still needs a one-bit counter that simply stays at zero.
  function automatic int cnt_width(input int dwell);
    return (dwell > 1) ? $clog2(dwell) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// Dwell timer: presets to DWELL-1 on load, counts down to zero on dec, and
// holds at zero until the next load.
// Ports:
//   clk   in  1  system clock, rising edge
//   rst_n in  1  asynchronous active-low reset (counter clears to 0)
//   load  in  1  preset the counter to DWELL-1 (wins over dec)
//   dec   in  1  decrement by one when not already zero
//   zero  out 1  counter is zero: the current dwell has elapsed
module dwell_timer #(
  parameter int DWELL = 20,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(DWELL - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its _d value from before the edge regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Mux scan sequencer: walks the select lines of an N_CH:1 mux through every
// channel, holds each one for DWELL cycles, samples the fed-back mux output
// at the end of each dwell and publishes the assembled word with a one-cycle
// done pulse. With a mux computing y = d[sel], word_out ends up equal to d.
// Ports:
//   clk        in  1      system clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   start      in  1      scan request, honoured only in IDLE
//   continuous in  1      rescan automatically after DONE (sampled in DONE)
//   abort      in  1      cancel a scan in progress; blocks start in IDLE
//   y_in       in  1      mux output fed back
//   sel        out SEL_W  registered mux select
//   busy       out 1      high in SETTLE and DONE
//   done       out 1      high for the single DONE cycle
//   word_out   out N_CH   last completed word; bit i sampled while sel==i
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W,
  parameter int DWELL = DEF_DWELL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic             y_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [N_CH-1:0]  word_out
);

  localparam int               CNT_W    = cnt_width(DWELL);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  // The last channel's bit goes straight into word_out, so the shadow only
  // holds the channels before it.
  logic [N_CH-2:0]  shadow_q, shadow_d;
  logic [N_CH-1:0]  word_q, word_d;
  logic             tmr_load, tmr_dec, tmr_zero;

  dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sel_d = '0;
        // abort in IDLE suppresses a simultaneous start.
        if (start && !abort) begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
        end
      end

      S_SETTLE: begin
        // abort outranks both the capture and the completion on this edge.
        if (abort) begin
          state_d = S_IDLE;
          sel_d   = '0;
        end else if (!tmr_zero) begin
          tmr_dec = 1'b1;
        end else if (sel_q != SEL_LAST) begin
          for (int i = 0; i < N_CH - 1; i++) begin
            if (sel_q == SEL_W'(i)) shadow_d[i] = y_in;
          end
          sel_d    = sel_q + SEL_W'(1);
          tmr_load = 1'b1;
        end else begin
          // Only publish point for word_out: a scan cut short by abort or
          // reset never reaches here.
          state_d = S_DONE;
          word_d  = {y_in, shadow_q};
        end
      end

      S_DONE: begin
        sel_d = '0;
        if (abort) begin
          state_d = S_IDLE;
        end else if (continuous) begin
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      // NOTE: shadow and word_out are plain flops, not a RAM, so resetting
      // them is cheap and guarantees no stale bits leak out after reset.
      shadow_q <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign word_out = word_q;

endmodule
